shared_slow_memory_arb: RTL and testbench

- Parametrised, synthesizable slow line-memory serving NUM_CH cache channels (e.g. I_cache and D_cache) from one shared storage array.
- Generalises the single-port slow memory with:
  - configurable line width, depth and latency;
  - round-robin arbitration between channels;
  - per-channel ready and read-data returns;
  - a shared-port busy flag and a per-channel wait-cycle counter for benches.
- Sits between CHIP cache miss ports and the memory image loaded by the top-level bench.

---
 rtl/shared_slow_memory_arb.sv | 162 ++++++++++++++++
 tb/tb_shared_slow_memory_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_slow_memory_arb.sv
// Shared line memory for NUM_CH cache channels; round-robin grant, one access in flight.
// Latency: grant edge E0 -> mem_ready pulse during cycle E0+LATENCY -> IDLE at E0+LATENCY+1.
// Backpressure: requests are level-held until that channel's ready; losers wait and count cycles.
module shared_slow_memory_arb #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 28,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          mem_read,
    input  logic [NUM_CH-1:0]          mem_write,
    input  logic [NUM_CH*ADDR_W-1:0]   mem_addr,
    input  logic [NUM_CH*LINE_W-1:0]   mem_wdata,
    output logic [NUM_CH*LINE_W-1:0]   mem_rdata,
    output logic [NUM_CH-1:0]          mem_ready,
    output logic                       busy,
    output logic [NUM_CH*CNT_W-1:0]    wait_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    cur_ch;
    logic               cur_wr;
    logic [IDX_W-1:0]   cur_idx;
    logic [LINE_W-1:0]  cur_wdata;
    logic [LAT_W-1:0]   lat_cnt;

    logic [LINE_W-1:0]  storage [DEPTH];

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   served;
    logic [2*NUM_CH-1:0] req_rot;
    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_ch;
    logic                gnt_wr;
    logic [IDX_W-1:0]    gnt_idx;
    logic [LINE_W-1:0]   gnt_wdata;
    logic                commit;
    logic                addr_unused;

    assign req     = mem_read | mem_write;
    assign req_rot = {req, req} >> rr_ptr;
    assign commit  = (state == BUSY) && (lat_cnt == '0);

    // Upper address bits only alias lines; fold them away so they are visibly ignored.
    assign addr_unused = ^mem_addr;

    // Rotated request vector: lowest set bit is the first requester at or after rr_ptr.
    always_comb begin
        int off;
        off     = 0;
        gnt_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_vld = 1'b1;
                off     = k;
            end
        end
        gnt_ch = CH_W'((int'(rr_ptr) + off) % NUM_CH);
    end

    always_comb begin
        gnt_wr    = 1'b0;
        gnt_idx   = '0;
        gnt_wdata = '0;
        served    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ch == CH_W'(i)) begin
                gnt_wr    = mem_write[i];
                gnt_idx   = mem_addr[i*ADDR_W +: IDX_W];
                gnt_wdata = mem_wdata[i*LINE_W +: LINE_W];
            end
            // The channel being served (or granted this edge) is not waiting.
            if (state == IDLE) begin
                served[i] = gnt_vld && (gnt_ch == CH_W'(i));
            end else begin
                served[i] = (cur_ch == CH_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && cur_wr) begin
            storage[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_ch    <= '0;
            cur_wr    <= 1'b0;
            cur_idx   <= '0;
            cur_wdata <= '0;
            lat_cnt   <= '0;
            mem_ready <= '0;
            mem_rdata <= '0;
            busy      <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            mem_ready <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (req[i] && !served[i] && (wait_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    wait_cnt[i*CNT_W +: CNT_W] <= wait_cnt[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        cur_ch    <= gnt_ch;
                        cur_wr    <= gnt_wr;
                        cur_idx   <= gnt_idx;
                        cur_wdata <= gnt_wdata;
                        rr_ptr    <= CH_W'((int'(gnt_ch) + 1) % NUM_CH);
                        lat_cnt   <= LAT_W'(LATENCY - 1);
                        state     <= BUSY;
                        busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cur_ch == CH_W'(i)) begin
                                mem_ready[i] <= 1'b1;
                                if (!cur_wr) begin
                                    mem_rdata[i*LINE_W +: LINE_W] <= storage[cur_idx];
                                end
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_slow_memory_arb.sv
// Bench for shared_slow_memory_arb: directed scenarios plus random traffic against a timestamp-based model.
module tb_shared_slow_memory_arb;

    localparam int N   = 2;
    localparam int LW  = 128;
    localparam int AW  = 28;
    localparam int D   = 1024;
    localparam int LAT = 4;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      mem_read;
    logic [N-1:0]      mem_write;
    logic [N*AW-1:0]   mem_addr;
    logic [N*LW-1:0]   mem_wdata;
    logic [N*LW-1:0]   mem_rdata;
    logic [N-1:0]      mem_ready;
    logic              busy;
    logic [N*CW-1:0]   wait_cnt;

    shared_slow_memory_arb #(
        .NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .DEPTH(D), .LATENCY(LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one access at a time, described by the edge it was granted
    // and the edge it completes (grant + LAT); the port frees one edge later.
    logic [LW-1:0] ref_mem [D];
    logic [LW-1:0] ref_rdata [N];
    int  ref_wait [N];
    int  edge_no   = 0;
    int  done_edge = -100;
    int  ref_rr    = 0;
    int  ref_ch    = 0;
    bit  ref_wr    = 1'b0;
    int  ref_line  = 0;
    logic [LW-1:0] ref_wdata;

    task automatic ref_step();
        logic [N-1:0] req;
        bit serving;
        int g;
        req = mem_read | mem_write;
        edge_no++;
        if (rst) begin
            done_edge = edge_no - 2;
            ref_rr = 0;
            for (int i = 0; i < N; i++) begin
                ref_rdata[i] = '0;
                ref_wait[i]  = 0;
            end
            return;
        end
        serving = (edge_no <= done_edge + 1);
        if (edge_no == done_edge) begin
            if (ref_wr) ref_mem[ref_line] = ref_wdata;
            else        ref_rdata[ref_ch] = ref_mem[ref_line];
        end
        g = -1;
        if (!serving) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req[(ref_rr + k) % N]) g = (ref_rr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && i != g && !(serving && i == ref_ch) && ref_wait[i] < (1 << CW) - 1)
                ref_wait[i]++;
        end
        if (g >= 0) begin
            ref_ch    = g;
            ref_wr    = mem_write[g];
            ref_line  = int'(mem_addr[g*AW +: AW]) % D;
            ref_wdata = mem_wdata[g*LW +: LW];
            ref_rr    = (g + 1) % N;
            done_edge = edge_no + LAT;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (edge_no == done_edge) exp_rdy[ref_ch] = 1'b1;
        check("busy", busy, (edge_no <= done_edge));
        check("ready", mem_ready, exp_rdy);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rdata%0d", i), mem_rdata[i*LW +: LW], ref_rdata[i]);
            check($sformatf("wait_cnt%0d", i), wait_cnt[i*CW +: CW], ref_wait[i]);
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        ref_step();
        #1;
        compare_all();
    endtask

    function automatic logic [LW-1:0] pat(input int l);
        logic [7:0] b;
        b = 8'hA0 | 8'(l & 15);
        return {16{b}};
    endfunction

    task automatic access(input int ch, input bit wr, input int addr, input logic [LW-1:0] d,
                          output int lat);
        lat = -1;
        mem_read[ch]  = !wr;
        mem_write[ch] = wr;
        mem_addr[ch*AW +: AW]  = AW'(addr);
        mem_wdata[ch*LW +: LW] = d;
        for (int t = 1; t <= 40 && lat < 0; t++) begin
            tick();
            if (mem_ready[ch]) lat = t;
        end
        mem_read[ch]  = 1'b0;
        mem_write[ch] = 1'b0;
        check("access_done", (lat > 0), 1);
        tick();
    endtask

    task automatic dual(input int a0, input int a1, output int t0, output int t1);
        t0 = -1;
        t1 = -1;
        mem_addr[0 +: AW]  = AW'(a0);
        mem_addr[AW +: AW] = AW'(a1);
        mem_read = 2'b11;
        for (int t = 1; t <= 40 && (t0 < 0 || t1 < 0); t++) begin
            tick();
            if (mem_ready[0] && t0 < 0) begin t0 = t; mem_read[0] = 1'b0; end
            if (mem_ready[1] && t1 < 0) begin t1 = t; mem_read[1] = 1'b0; end
        end
        mem_read = '0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat, t0, t1, cnt;
        int order [20];
        bit act [N];
        logic [LW-1:0] v;
        rst = 1'b1;
        mem_read = '0;
        mem_write = '0;
        mem_addr = '0;
        mem_wdata = '0;
        for (int i = 0; i < N; i++) begin
            ref_rdata[i] = '0;
            ref_wait[i]  = 0;
            act[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_wait", wait_cnt, 0);

        for (int l = 0; l < 16; l++) access(0, 1'b1, l, pat(l), lat);

        access(0, 1'b0, 5, '0, lat);
        check("rd5_latency", lat, LAT + 1);
        check("rd5_data", mem_rdata[0 +: LW], pat(5));

        access(1, 1'b1, 3, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_F625, lat);
        check("wr_keeps_rdata1", mem_rdata[LW +: LW], 0);
        access(1, 1'b0, 3, '0, lat);
        check("rd3_after_wr", mem_rdata[LW +: LW], 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_F625);

        v = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        access(0, 1'b1, 1029, v, lat);
        access(1, 1'b0, 5, '0, lat);
        check("alias_1029_5", mem_rdata[LW +: LW], v);

        mem_write[0] = 1'b1;
        mem_addr[0 +: AW]  = AW'(7);
        mem_wdata[0 +: LW] = {4{32'hCAFE_F00D}};
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        mem_write[0] = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_ready", mem_ready, 0);
        tick();
        check("post_rst_ready", mem_ready, 0);
        access(1, 1'b0, 7, '0, lat);
        check("line7_unchanged", mem_rdata[LW +: LW], pat(7));

        do_reset();
        dual(1, 2, t0, t1);
        check("dual_a_t0", t0, LAT + 1);
        check("dual_a_t1", t1, 2 * LAT + 3);
        check("dual_a_wait1", wait_cnt[CW +: CW], 6);
        access(0, 1'b0, 4, '0, lat);
        dual(8, 9, t0, t1);
        check("dual_b_t1", t1, LAT + 1);
        check("dual_b_t0", t0, 2 * LAT + 3);
        check("dual_b_wait0", wait_cnt[0 +: CW], 6);

        do_reset();
        mem_addr[0 +: AW]  = AW'(1);
        mem_addr[AW +: AW] = AW'(2);
        mem_read = 2'b11;
        cnt = 0;
        for (int t = 0; t < 300 && cnt < 20; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (mem_ready[i] && cnt < 20) begin
                    order[cnt] = i;
                    cnt++;
                end
            end
        end
        check("fair_count", cnt, 20);
        for (int k = 0; k < 20; k++) check($sformatf("fair_order%0d", k), order[k], k % 2);
        check("fair_wait0", wait_cnt[0 +: CW], 59);
        check("fair_wait1", wait_cnt[CW +: CW], 60);
        mem_read = '0;
        tick();
        tick();

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (act[i] && (mem_ready[i] || $urandom_range(0, 31) == 0)) begin
                    act[i] = 1'b0;
                    mem_read[i] = 1'b0;
                    mem_write[i] = 1'b0;
                end else if (!act[i] && $urandom_range(0, 2) == 0) begin
                    int op;
                    op = $urandom_range(1, 3);
                    act[i] = 1'b1;
                    mem_read[i]  = op[0];
                    mem_write[i] = op[1];
                    mem_addr[i*AW +: AW]  = AW'($urandom_range(0, 15) + D * $urandom_range(0, 3));
                    mem_wdata[i*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
